// File: rtl/compare_sort_ctrl.sv
// compare_sort_ctrl: loads DEPTH elements, bubble-sorts them in place with a
// single time-shared unsigned A>B compare, then streams them out ascending.
// Optional feature macro: SORT_SWAP_CNT_EN adds an 8-bit saturating swap_count
// output that counts swaps in the current batch.
module compare_sort_ctrl #(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
`ifdef SORT_SWAP_CNT_EN
    ,
    output logic [7:0]       swap_count
`endif
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(DEPTH - 1);
    localparam logic [IW-1:0] LAST_CMP = IW'(DEPTH - 2);

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [IW-1:0]    wr_idx_q, wr_idx_d;
    logic [IW-1:0]    rd_idx_q, rd_idx_d;
    logic [IW-1:0]    cmp_idx_q, cmp_idx_d;
    logic [IW-1:0]    pass_q, pass_d;
    logic             swapped_q, swapped_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [IW-1:0]    cmp_nxt;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             gt;
    logic             pass_swap;
    logic             load_fire;

    // Shared comparator: operands are always the current adjacent pair
    always_comb begin
        cmp_nxt   = cmp_idx_q + IW'(1);
        cmp_a     = mem_q[cmp_idx_q];
        cmp_b     = mem_q[cmp_nxt];
        gt        = (cmp_a > cmp_b);
        pass_swap = swapped_q | gt;
        load_fire = (state_q == S_LOAD) && in_valid && in_ready_q;
    end

    // Next-state, buffer update and registered-output targets
    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_idx_d  = wr_idx_q;
        rd_idx_d  = rd_idx_q;
        cmp_idx_d = cmp_idx_q;
        pass_d    = pass_q;
        swapped_d = swapped_q;
        done_d    = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (load_fire) begin
                    mem_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        wr_idx_d  = '0;
                        cmp_idx_d = '0;
                        pass_d    = '0;
                        swapped_d = 1'b0;
                        state_d   = S_SORT;
                    end else begin
                        wr_idx_d = wr_idx_q + IW'(1);
                    end
                end
            end
            S_SORT: begin
                if (gt) begin
                    mem_d[cmp_idx_q] = cmp_b;
                    mem_d[cmp_nxt]   = cmp_a;
                end
                if (cmp_idx_q == LAST_CMP) begin
                    cmp_idx_d = '0;
                    swapped_d = 1'b0;
                    // A clean pass means sorted; otherwise stop after DEPTH-1 passes
                    if (!pass_swap || (pass_q == LAST_CMP)) begin
                        pass_d   = '0;
                        rd_idx_d = '0;
                        state_d  = S_OUT;
                    end else begin
                        pass_d = pass_q + IW'(1);
                    end
                end else begin
                    cmp_idx_d = cmp_nxt;
                    swapped_d = pass_swap;
                end
            end
            S_OUT: begin
                if (out_valid_q && out_ready) begin
                    if (rd_idx_q == LAST_IDX) begin
                        rd_idx_d = '0;
                        done_d   = 1'b1;
                        state_d  = S_LOAD;
                    end else begin
                        rd_idx_d = rd_idx_q + IW'(1);
                    end
                end
            end
            default: state_d = S_LOAD;
        endcase

        in_ready_d  = (state_d == S_LOAD);
        out_valid_d = (state_d == S_OUT);
        busy_d      = (state_d == S_SORT) || (state_d == S_OUT);
        out_data_d  = out_valid_d ? mem_d[rd_idx_d] : out_data_q;
    end

    // State, buffer and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            mem_q       <= '{default: '0};
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            cmp_idx_q   <= '0;
            pass_q      <= '0;
            swapped_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_q       <= mem_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            cmp_idx_q   <= cmp_idx_d;
            pass_q      <= pass_d;
            swapped_q   <= swapped_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;

`ifdef SORT_SWAP_CNT_EN
    logic [7:0] swap_cnt_q, swap_cnt_d;

    // Per-batch saturating swap counter, cleared by the first element loaded
    always_comb begin
        swap_cnt_d = swap_cnt_q;
        if (load_fire && (wr_idx_q == '0)) begin
            swap_cnt_d = '0;
        end else if ((state_q == S_SORT) && gt && (swap_cnt_q != 8'hFF)) begin
            swap_cnt_d = swap_cnt_q + 8'd1;
        end
    end

    // Swap counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_cnt_q <= '0;
        end else begin
            swap_cnt_q <= swap_cnt_d;
        end
    end

    assign swap_count = swap_cnt_q;
`endif

endmodule
